// File: rtl/lsu_handshake_pkg.sv
// lsu_handshake_pkg
// Shared definitions for the load/store handshake unit: load-type and
// store-mask encodings as seen on the execute interface, the FSM state
// type, and the alignment check used at op acceptance.
`timescale 1ns/1ps
package lsu_handshake_pkg;

   // Load type codes on e_load_inst (codes 6 and 7 behave as LD_W)
   localparam logic [2:0] LD_NONE = 3'd0;
   localparam logic [2:0] LD_B    = 3'd1;
   localparam logic [2:0] LD_H    = 3'd2;
   localparam logic [2:0] LD_W    = 3'd3;
   localparam logic [2:0] LD_BU   = 3'd4;
   localparam logic [2:0] LD_HU   = 3'd5;

   // Unshifted store byte masks on e_store_mask
   localparam logic [3:0] SM_NONE = 4'b0000;
   localparam logic [3:0] SM_B    = 4'b0001;
   localparam logic [3:0] SM_H    = 4'b0011;
   localparam logic [3:0] SM_W    = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } lsuState_t;

   // Access size is taken from the store mask when one is present (a store
   // overrides any load type), otherwise from the load type. Any nonzero
   // mask that is not a byte or halfword mask is sized as a word.
   function automatic logic isMisaligned(input logic [2:0] loadInst,
                                         input logic [3:0] storeMask,
                                         input logic [1:0] byteOffset);
      logic isHalf;
      logic isWord;
      isHalf = 1'b0;
      isWord = 1'b0;
      if (storeMask != SM_NONE) begin
         isHalf = (storeMask == SM_H);
         isWord = (storeMask != SM_B) && (storeMask != SM_H);
      end else begin
         isHalf = (loadInst == LD_H) || (loadInst == LD_HU);
         isWord = (loadInst == LD_W) || (loadInst >= 3'd6);
      end
      return (isHalf && byteOffset[0]) || (isWord && (byteOffset != 2'b00));
   endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align
// Purely combinational byte-lane alignment for a 32-bit word memory.
//   byteOffset  in  : address bits [1:0] of the access
//   storeMask   in  : unshifted store byte mask
//   storeData   in  : unshifted store data (rs2)
//   loadInst    in  : load type code
//   rawRdata    in  : raw word returned by memory
//   laneMask    out : store byte enables moved onto the addressed lanes
//   laneData    out : store data moved onto the addressed lanes
//   loadData    out : load result, extracted and sign/zero extended
`timescale 1ns/1ps
module lsu_align
   import lsu_handshake_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [1:0]            byteOffset,
   input  logic [3:0]            storeMask,
   input  logic [DATA_WIDTH-1:0] storeData,
   input  logic [2:0]            loadInst,
   input  logic [DATA_WIDTH-1:0] rawRdata,
   output logic [3:0]            laneMask,
   output logic [DATA_WIDTH-1:0] laneData,
   output logic [DATA_WIDTH-1:0] loadData
);

   logic [4:0]            shiftBits;
   logic [DATA_WIDTH-1:0] rdShifted;

   assign shiftBits = {byteOffset, 3'b000};
   assign laneMask  = storeMask << byteOffset;
   assign laneData  = storeData << shiftBits;
   // Bring the addressed byte/halfword down to bit 0 before extension
   assign rdShifted = rawRdata >> shiftBits;

   always_comb begin
      loadData = rdShifted;
      case (loadInst)
         LD_B:    loadData = {{(DATA_WIDTH-8){rdShifted[7]}},   rdShifted[7:0]};
         LD_H:    loadData = {{(DATA_WIDTH-16){rdShifted[15]}}, rdShifted[15:0]};
         LD_BU:   loadData = {{(DATA_WIDTH-8){1'b0}},           rdShifted[7:0]};
         LD_HU:   loadData = {{(DATA_WIDTH-16){1'b0}},          rdShifted[15:0]};
         default: loadData = rdShifted;
      endcase
   end

endmodule

// File: rtl/lsu_handshake.sv
// lsu_handshake
// Load/store stage between execute and write-back. Accepts one op at a
// time over a valid/ready handshake, issues at most one request to a
// variable-latency data memory, and hands the register write to
// write-back over a second valid/ready handshake.
//   clk, rst                    : clock, asynchronous active-high reset
//   in_valid/in_ready           : op handshake from execute
//   e_regW/e_regAddr/e_regData  : destination and ALU result / address
//   e_load_inst/e_store_mask    : memory op selection
//   e_store_data                : unshifted store data
//   mem_req_valid/mem_req_ready : memory request handshake
//   mem_addr/mem_wen/mem_wmask/mem_wdata : request payload
//   mem_resp_valid/mem_rdata    : one-cycle memory response
//   m_valid/m_ready             : result handshake to write-back
//   m_regW/m_regAddr/m_regData  : register write result
//   m_misalign                  : result of a rejected misaligned access
`timescale 1ns/1ps
module lsu_handshake
   import lsu_handshake_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  e_regW,
   input  logic [ADDR_WIDTH-1:0] e_regAddr,
   input  logic [DATA_WIDTH-1:0] e_regData,
   input  logic [2:0]            e_load_inst,
   input  logic [3:0]            e_store_mask,
   input  logic [DATA_WIDTH-1:0] e_store_data,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic                  mem_wen,
   output logic [3:0]            mem_wmask,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_resp_valid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_regW,
   output logic [ADDR_WIDTH-1:0] m_regAddr,
   output logic [DATA_WIDTH-1:0] m_regData,
   output logic                  m_misalign
);

   lsuState_t             stateReg;
   lsuState_t             stateNext;

   logic                  regWReg;
   logic [ADDR_WIDTH-1:0] regAddrReg;
   logic [DATA_WIDTH-1:0] addrReg;
   logic [DATA_WIDTH-1:0] resultReg;
   logic [3:0]            storeMaskReg;
   logic [DATA_WIDTH-1:0] storeDataReg;
   logic [2:0]            loadInstReg;
   logic                  isStoreReg;
   logic                  misalignReg;

   logic                  accept;
   logic                  acceptIsStore;
   logic                  acceptIsMem;
   logic                  acceptMisalign;
   logic [DATA_WIDTH-1:0] alignedLoad;

   assign accept         = (stateReg == ST_IDLE) && in_valid;
   assign acceptIsStore  = (e_store_mask != SM_NONE);
   assign acceptIsMem    = acceptIsStore || (e_load_inst != LD_NONE);
   assign acceptMisalign = acceptIsMem &&
                           isMisaligned(e_load_inst, e_store_mask, e_regData[1:0]);

   // Alignment works entirely from latched op state, so every request
   // field stays stable for as long as the request is stalled.
   lsu_align #(
      .DATA_WIDTH (DATA_WIDTH)
   ) uAlign (
      .byteOffset (addrReg[1:0]),
      .storeMask  (storeMaskReg),
      .storeData  (storeDataReg),
      .loadInst   (loadInstReg),
      .rawRdata   (mem_rdata),
      .laneMask   (mem_wmask),
      .laneData   (mem_wdata),
      .loadData   (alignedLoad)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateReg <= ST_IDLE;
      end else begin
         stateReg <= stateNext;
      end
   end

   always_comb begin
      stateNext     = stateReg;
      in_ready      = 1'b0;
      mem_req_valid = 1'b0;
      m_valid       = 1'b0;
      case (stateReg)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (!acceptIsMem || acceptMisalign) begin
                  stateNext = ST_RESP;
               end else begin
                  stateNext = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) begin
               stateNext = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (mem_resp_valid) begin
               stateNext = ST_RESP;
            end
         end
         ST_RESP: begin
            m_valid = 1'b1;
            if (m_ready) begin
               stateNext = ST_IDLE;
            end
         end
         default: stateNext = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regWReg      <= 1'b0;
         regAddrReg   <= '0;
         addrReg      <= '0;
         resultReg    <= '0;
         storeMaskReg <= SM_NONE;
         storeDataReg <= '0;
         loadInstReg  <= LD_NONE;
         isStoreReg   <= 1'b0;
         misalignReg  <= 1'b0;
      end else if (accept) begin
         // Stores and rejected accesses never write the register file
         regWReg      <= e_regW && !acceptIsStore && !acceptMisalign;
         regAddrReg   <= e_regAddr;
         addrReg      <= e_regData;
         resultReg    <= e_regData;
         storeMaskReg <= e_store_mask;
         storeDataReg <= e_store_data;
         // A store overrides any load type presented alongside it
         loadInstReg  <= acceptIsStore ? LD_NONE : e_load_inst;
         isStoreReg   <= acceptIsStore && !acceptMisalign;
         misalignReg  <= acceptMisalign;
      end else if ((stateReg == ST_WAIT) && mem_resp_valid && !isStoreReg) begin
         resultReg    <= alignedLoad;
      end
   end

   assign mem_addr   = {addrReg[DATA_WIDTH-1:2], 2'b00};
   assign mem_wen    = isStoreReg;
   assign m_regAddr  = regAddrReg;
   assign m_regData  = resultReg;
   assign m_regW     = m_valid && regWReg;
   assign m_misalign = m_valid && misalignReg;

endmodule
